// File: rtl/regfile_arb_pkg.sv
// Shared types and defaults for the register-file arbiter: FSM states, owner ids,
// default address/data widths.
package regfile_arb_pkg;

  localparam int M_DEF = 4;
  localparam int W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR    = 2'd1,
    RD    = 2'd2,
    RWAIT = 2'd3
  } state_t;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

endpackage

// File: rtl/regfile_arbiter_if.sv
// Requester-side command/response bundle; one instance per requester port.
// master = the requester, slave = the arbiter.
interface regfile_arbiter_if
  import regfile_arb_pkg::*;
#(
  parameter int M = M_DEF,
  parameter int W = W_DEF
) ();

  logic         req;
  logic         we;
  logic [M-1:0] waddr;
  logic [W-1:0] wdata;
  logic [M-1:0] raddr1;
  logic [M-1:0] raddr2;
  logic [M-1:0] raddr3;
  logic         gnt;
  logic         rvalid;
  logic [W-1:0] rdata1;
  logic [W-1:0] rdata2;
  logic [W-1:0] rdata3;

  modport master (
    output req, we, waddr, wdata, raddr1, raddr2, raddr3,
    input  gnt, rvalid, rdata1, rdata2, rdata3
  );

  modport slave (
    input  req, we, waddr, wdata, raddr1, raddr2, raddr3,
    output gnt, rvalid, rdata1, rdata2, rdata3
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. The pointer names the requester that wins a tie
// and moves to the loser of each accepted grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       pointer
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = pointer ? 2'b10 : 2'b01;
  end

  // After granting A the pointer goes to B (1); after granting B it goes to A (0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pointer <= 1'b0;
    else if (advance) pointer <= gnt[0];
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Serialises port A / port B register-file commands: one operation at a time,
// read data returned to the issuing port with a one-cycle rvalid pulse.
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int M = M_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_arbiter_if.slave port_a,
  regfile_arbiter_if.slave port_b,
  output logic         rf_we,
  output logic [M-1:0] rf_waddr,
  output logic [W-1:0] rf_wdata,
  output logic         rf_re,
  output logic [M-1:0] rf_raddr1,
  output logic [M-1:0] rf_raddr2,
  output logic [M-1:0] rf_raddr3,
  input  logic [W-1:0] rf_rdata1,
  input  logic [W-1:0] rf_rdata2,
  input  logic [W-1:0] rf_rdata3
);

  typedef struct packed {
    logic [M-1:0] waddr;
    logic [W-1:0] wdata;
    logic [M-1:0] raddr1;
    logic [M-1:0] raddr2;
    logic [M-1:0] raddr3;
  } cmd_t;

  state_t          state;
  owner_t          owner;
  cmd_t            cmd;
  cmd_t            cmd_a;
  cmd_t            cmd_b;
  cmd_t            cmd_sel;
  logic            we_sel;
  logic [1:0]      arb_req;
  logic [1:0]      arb_gnt;
  logic            ptr_unused;
  logic            rvalid_a;
  logic            rvalid_b;
  logic [2:0][W-1:0] rd_a;
  logic [2:0][W-1:0] rd_b;

  assign cmd_a = {port_a.waddr, port_a.wdata, port_a.raddr1, port_a.raddr2, port_a.raddr3};
  assign cmd_b = {port_b.waddr, port_b.wdata, port_b.raddr1, port_b.raddr2, port_b.raddr3};

  // Requests are only offered to the picker in IDLE, so grants cannot occur mid-operation.
  assign arb_req = {port_b.req, port_a.req} & {2{state == IDLE}};
  assign cmd_sel = arb_gnt[1] ? cmd_b : cmd_a;
  assign we_sel  = arb_gnt[1] ? port_b.we : port_a.we;

  rr_arb2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .advance (|arb_gnt),
    .gnt     (arb_gnt),
    .pointer (ptr_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= OWN_A;
      cmd      <= '0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      rd_a     <= '0;
      rd_b     <= '0;
    end else begin
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      case (state)
        IDLE: begin
          if (|arb_gnt) begin
            cmd   <= cmd_sel;
            owner <= arb_gnt[1] ? OWN_B : OWN_A;
            state <= we_sel ? WR : RD;
          end
        end
        WR:    state <= IDLE;
        RD:    state <= RWAIT;
        RWAIT: begin
          // Register file output is valid now; the pulse lands in the following IDLE cycle.
          if (owner == OWN_B) begin
            rd_b     <= {rf_rdata1, rf_rdata2, rf_rdata3};
            rvalid_b <= 1'b1;
          end else begin
            rd_a     <= {rf_rdata1, rf_rdata2, rf_rdata3};
            rvalid_a <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rf_we     = (state == WR);
  assign rf_re     = (state == RD);
  assign rf_waddr  = cmd.waddr;
  assign rf_wdata  = cmd.wdata;
  assign rf_raddr1 = cmd.raddr1;
  assign rf_raddr2 = cmd.raddr2;
  assign rf_raddr3 = cmd.raddr3;

  assign port_a.gnt    = arb_gnt[0];
  assign port_b.gnt    = arb_gnt[1];
  assign port_a.rvalid = rvalid_a;
  assign port_b.rvalid = rvalid_b;
  assign port_a.rdata1 = rd_a[2];
  assign port_a.rdata2 = rd_a[1];
  assign port_a.rdata3 = rd_a[0];
  assign port_b.rdata1 = rd_b[2];
  assign port_b.rdata2 = rd_b[1];
  assign port_b.rdata3 = rd_b[0];

endmodule
